// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: load/store unit between the single-cycle core data port and data memory.
// One access at a time: IDLE -> WAIT -> DONE -> IDLE. The core is stalled until DONE.
// A watchdog aborts an access after TIMEOUT_CYCLES wait cycles without mem_ready_i.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (misaligned H/HU/W aborted in IDLE, no memory request).
module riscv_lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       size_q;
   logic [1:0]       lane_q;
   logic             timeout_hit;
   logic             misalign;

   // Byte enables: sizes 3/6/7 fall through to a full word.
   function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         3'd0, 3'd4: calc_be = 4'b0001 << lo;
         3'd1, 3'd5: calc_be = 4'b0011 << {lo[1], 1'b0};
         default:    calc_be = 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned store data onto every lane so the byte enables pick the right one.
   function automatic logic [31:0] calc_wd(input logic [2:0] size, input logic [31:0] wd);
      case (size)
         3'd0, 3'd4: calc_wd = {4{wd[7:0]}};
         3'd1, 3'd5: calc_wd = {2{wd[15:0]}};
         default:    calc_wd = wd;
      endcase
   endfunction

   // Pick the addressed lane out of the memory word and sign/zero-extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [2:0] size,
                                                input logic [1:0] lo);
      logic [31:0] byte_w;
      logic [31:0] half_w;
      byte_w = rd >> {lo, 3'b000};
      half_w = rd >> {lo[1], 4'b0000};
      case (size)
         3'd0:    load_extract = {{24{byte_w[7]}}, byte_w[7:0]};
         3'd4:    load_extract = {24'd0, byte_w[7:0]};
         3'd1:    load_extract = {{16{half_w[15]}}, half_w[15:0]};
         3'd5:    load_extract = {16'd0, half_w[15:0]};
         default: load_extract = rd;
      endcase
   endfunction

`ifdef LSU_MISALIGN_CHECK_EN
   // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         3'd0, 3'd4: is_misaligned = 1'b0;
         3'd1, 3'd5: is_misaligned = lo[0];
         default:    is_misaligned = (lo != 2'b00);
      endcase
   endfunction

   assign misalign = is_misaligned(core_size_i, core_addr_i[1:0]);
`else
   assign misalign = 1'b0;
`endif

   assign timeout_hit  = (state_q == S_WAIT) && !mem_ready_i &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign core_stall_o = core_req_i && (state_q != S_DONE);

   // Next-state logic; ready wins over a simultaneous timeout, DONE never re-accepts the request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (core_req_i) state_d = misalign ? S_DONE : S_WAIT;
         S_WAIT:  if (mem_ready_i || timeout_hit) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Memory request, captured access attributes, watchdog and core response registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         size_q     <= 3'd0;
         lane_q     <= 2'd0;
         mem_req_o  <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_be_o   <= 4'd0;
         mem_addr_o <= 32'd0;
         mem_wd_o   <= 32'd0;
         core_rd_o  <= 32'd0;
         err_o      <= 1'b0;
      end else begin
         cnt_q <= (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
         case (state_q)
            S_IDLE: begin
               if (state_d == S_WAIT) begin
                  mem_req_o  <= 1'b1;
                  mem_we_o   <= core_we_i;
                  mem_be_o   <= calc_be(core_size_i, core_addr_i[1:0]);
                  mem_addr_o <= {core_addr_i[31:2], 2'b00};
                  mem_wd_o   <= calc_wd(core_size_i, core_wd_i);
                  size_q     <= core_size_i;
                  lane_q     <= core_addr_i[1:0];
               end else if (state_d == S_DONE) begin
                  core_rd_o <= 32'd0;
                  err_o     <= 1'b1;
               end
            end
            S_WAIT: begin
               if (state_d == S_DONE) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  mem_be_o  <= 4'd0;
                  err_o     <= !mem_ready_i;
                  core_rd_o <= (mem_ready_i && !mem_we_o) ? load_extract(mem_rd_i, size_q, lane_q)
                                                          : 32'd0;
               end
            end
            default: err_o <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// tb_riscv_lsu_ctrl: scoreboard bench for riscv_lsu_ctrl (default 64-cycle watchdog instance plus
// a 4-cycle watchdog instance whose memory never answers).
`timescale 1ns/1ps
module tb_riscv_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        core_req = 1'b0, req_to = 1'b0;
   logic        core_we = 1'b0;
   logic [2:0]  core_size = 3'd2;
   logic [31:0] core_addr = 32'd0, core_wd = 32'd0;
   logic [31:0] mem_rd = 32'd0;
   logic        mem_ready = 1'b0;

   logic [31:0] core_rd, mem_addr, mem_wd;
   logic        core_stall, err, mem_req, mem_we;
   logic [3:0]  mem_be;

   logic [31:0] to_rd, to_addr, to_wd;
   logic        to_stall, to_err, to_req, to_we;
   logic [3:0]  to_be;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   riscv_lsu_ctrl dut (
      .clk_i(clk), .rst_ni(rst_ni), .core_req_i(core_req), .core_we_i(core_we),
      .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
      .core_rd_o(core_rd), .core_stall_o(core_stall), .err_o(err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
   );

   riscv_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk_i(clk), .rst_ni(rst_ni), .core_req_i(req_to), .core_we_i(core_we),
      .core_size_i(core_size), .core_addr_i(core_addr), .core_wd_i(core_wd),
      .core_rd_o(to_rd), .core_stall_o(to_stall), .err_o(to_err),
      .mem_req_o(to_req), .mem_we_o(to_we), .mem_be_o(to_be), .mem_addr_o(to_addr),
      .mem_wd_o(to_wd), .mem_rd_i(32'hA5A5A5A5), .mem_ready_i(1'b0)
   );

   // Reference models (arithmetic formulation, independent of the RTL's shifting/replication).
   function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [2:0] size, input int off);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*off +: 8];
      h = rd[16*(off/2) +: 16];
      case (size)
         3'd0:    m_load = (b >= 8'd128) ? 32'(b) - 32'd256 : 32'(b);
         3'd4:    m_load = 32'(b);
         3'd1:    m_load = (h >= 16'd32768) ? 32'(h) - 32'h10000 : 32'(h);
         3'd5:    m_load = 32'(h);
         default: m_load = rd;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] size, input int off);
      case (size)
         3'd0, 3'd4: m_be = (off == 0) ? 4'h1 : (off == 1) ? 4'h2 : (off == 2) ? 4'h4 : 4'h8;
         3'd1, 3'd5: m_be = (off < 2) ? 4'h3 : 4'hC;
         default:    m_be = 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
      case (size)
         3'd0, 3'd4: m_wd = 32'(wd[7:0]) * 32'h01010101;
         3'd1, 3'd5: m_wd = 32'(wd[15:0]) * 32'h00010001;
         default:    m_wd = wd;
      endcase
   endfunction

   // One full access on the main instance; entered just after a rising edge with the DUT idle.
   task automatic do_access(input string name, input logic we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                            input int waits, input logic [3:0] exp_be, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rd);
      int   stallc = 0;
      int   wcnt = 0;
      bit   done = 0;
      exp_t e;
      core_we = we; core_size = size; core_addr = addr; core_wd = wd;
      core_req = 1'b1;
      sb.push_back('{rd: exp_rd, err: 1'b0});
      for (int c = 0; c < 300 && !done; c++) begin
         @(negedge clk);
         if (!core_stall) done = 1;
         else begin
            stallc++;
            if (mem_req) begin
               wcnt++;
               tests++;
               if ({mem_we, mem_be, mem_addr, mem_wd} !== {we, exp_be, exp_addr, exp_wd}) begin
                  fails++;
                  $display("FAIL %s wait%0d: we/be/addr/wd got %b/%h/%h/%h want %b/%h/%h/%h", name,
                           wcnt, mem_we, mem_be, mem_addr, mem_wd, we, exp_be, exp_addr, exp_wd);
               end
               mem_ready = (wcnt == waits + 1);
               mem_rd    = mem_ready ? rdata : ~rdata;
            end
         end
      end
      mem_ready = 1'b0;
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL %s: no DONE within cycle budget, got stall=1 want stall=0", name);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (core_rd !== e.rd || err !== e.err) begin
            fails++;
            $display("FAIL %s: rd/err got %h/%b want %h/%b", name, core_rd, err, e.rd, e.err);
         end
         tests++;
         if (stallc != waits + 2 || wcnt != waits + 1) begin
            fails++;
            $display("FAIL %s: stall/wait cycles got %0d/%0d want %0d/%0d", name, stallc, wcnt,
                     waits + 2, waits + 1);
         end
         tests++;
         if ({mem_req, mem_we, mem_be} !== 6'd0) begin
            fails++;
            $display("FAIL %s done: req/we/be got %b/%b/%h want 0/0/0", name, mem_req, mem_we, mem_be);
         end
      end
      @(posedge clk); #1;
      core_req = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, err, core_stall, to_req} !== '0) begin
         fails++;
         $display("FAIL reset: req=%b we=%b be=%h addr=%h wd=%h rd=%h err=%b stall=%b to_req=%b want all 0",
                  mem_req, mem_we, mem_be, mem_addr, mem_wd, core_rd, err, core_stall, to_req);
      end
      @(negedge clk); rst_ni = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_lw();
      do_access("lw_0x100", 1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0, 4'hF, 32'h100, 32'd0,
                32'hDEADBEEF);
   endtask

   task automatic test_lb_lbu();
      do_access("lb_0x103", 1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF1234, 0, 4'b1000, 32'h100, 32'd0,
                32'hFFFFFF80);
      do_access("lbu_0x103", 1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF1234, 1, 4'b1000, 32'h100, 32'd0,
                32'h00000080);
   endtask

   task automatic test_sh_waits();
      do_access("sh_0x202", 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h12345678, 4, 4'b1100, 32'h200,
                32'hABCDABCD, 32'd0);
   endtask

   task automatic test_lanes();
      logic [31:0] d;
      logic [2:0]  sizes [4];
      d = 32'h9C7F8001;
      sizes = '{3'd0, 3'd4, 3'd1, 3'd5};
      foreach (sizes[s]) begin
         for (int off = 0; off < 4; off++) begin
            if (sizes[s] == 3'd0 || sizes[s] == 3'd4 || off % 2 == 0)
               do_access($sformatf("lane_s%0d_o%0d", sizes[s], off), 1'b0, sizes[s], 32'h300 + off,
                         32'd0, d, 0, m_be(sizes[s], off), 32'h300, 32'd0, m_load(d, sizes[s], off));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  sizes [6];
      logic [2:0]  sz;
      logic [31:0] a, wd, rd;
      logic        we;
      int          off;
      sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
      for (int i = 0; i < 10; i++) begin
         sz  = sizes[$urandom_range(5)];
         we  = ($urandom_range(1) == 1) && (sz < 3'd3);
         off = $urandom_range(3);
         if (sz == 3'd1 || sz == 3'd5) off = off & 2;
         else if (sz != 3'd0 && sz != 3'd4) off = 0;
         a  = {$urandom(), 2'b00} + 32'(off);
         wd = $urandom();
         rd = $urandom();
         do_access($sformatf("b2b_%0d", i), we, sz, a, wd, rd, $urandom_range(3), m_be(sz, off),
                   {a[31:2], 2'b00}, m_wd(sz, wd), we ? 32'd0 : m_load(rd, sz, off));
      end
   endtask

   task automatic test_timeout();
      int   reqc = 0;
      bit   done = 0;
      exp_t e;
      core_we = 1'b0; core_size = 3'd2; core_addr = 32'h40;
      req_to = 1'b1;
      sb.push_back('{rd: 32'd0, err: 1'b1});
      for (int c = 0; c < 30 && !done; c++) begin
         @(negedge clk);
         if (!to_stall) done = 1;
         else if (to_req) reqc++;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL timeout: no DONE within cycle budget, got stall=1 want stall=0");
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         if (to_rd !== e.rd || to_err !== e.err || to_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout done: rd/err/req got %h/%b/%b want %h/%b/0", to_rd, to_err, to_req,
                     e.rd, e.err);
         end
      end
      tests++;
      if (reqc != 4) begin
         fails++;
         $display("FAIL timeout req cycles: got %0d want 4", reqc);
      end
      @(posedge clk); #1;
      req_to = 1'b0;
      @(negedge clk);
      tests++;
      if ({to_err, to_req, to_stall} !== 3'b000) begin
         fails++;
         $display("FAIL timeout after: err/req/stall got %b/%b/%b want 0/0/0", to_err, to_req, to_stall);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      bit inwait = 0;
      core_we = 1'b0; core_size = 3'd2; core_addr = 32'h500;
      core_req = 1'b1;
      for (int c = 0; c < 5 && !inwait; c++) begin
         @(negedge clk);
         if (mem_req) inwait = 1;
      end
      @(negedge clk);
      #1 rst_ni = 1'b0;
      #1;
      tests++;
      if (!inwait || {mem_req, mem_be} !== 5'd0) begin
         fails++;
         $display("FAIL reset_mid: inwait=%b req/be got %b/%h want 0/0", inwait, mem_req, mem_be);
      end
      core_req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst_ni = 1'b1;
      tests++;
      if ({mem_req, err, core_rd} !== 34'd0) begin
         fails++;
         $display("FAIL reset_mid released: req/err/rd got %b/%b/%h want 0/0/0", mem_req, err, core_rd);
      end
      @(posedge clk); #1;
      do_access("lw_after_reset", 1'b0, 3'd2, 32'h504, 32'd0, 32'h0BADF00D, 0, 4'hF, 32'h504, 32'd0,
                32'h0BADF00D);
   endtask

   task automatic test_misalign();
`ifdef LSU_MISALIGN_CHECK_EN
      bit   sawreq = 0;
      exp_t e;
      core_we = 1'b0; core_size = 3'd2; core_addr = 32'h101;
      core_req = 1'b1;
      sb.push_back('{rd: 32'd0, err: 1'b1});
      @(negedge clk);
      sawreq = mem_req;
      tests++;
      if (core_stall !== 1'b1) begin
         fails++;
         $display("FAIL misalign idle: stall got %b want 1", core_stall);
      end
      @(negedge clk);
      sawreq = sawreq | mem_req;
      e = sb.pop_front();
      tests++;
      if (core_stall !== 1'b0 || err !== e.err || core_rd !== e.rd || sawreq) begin
         fails++;
         $display("FAIL misalign done: stall/err/rd/req got %b/%b/%h/%b want 0/%b/%h/0", core_stall, err,
                  core_rd, sawreq, e.err, e.rd);
      end
      @(posedge clk); #1;
      core_req = 1'b0;
`else
      do_access("lw_misaligned", 1'b0, 3'd2, 32'h101, 32'd0, 32'hCAFEF00D, 0, 4'hF, 32'h100, 32'd0,
                32'hCAFEF00D);
`endif
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh_waits();
      test_lanes();
      test_timeout();
      test_reset_mid();
      test_misalign();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "time limit");
   end

endmodule
